// File: rtl/vrased_reset_seq.sv
// -----------------------------------------------------------------------------
// vrased_reset_seq
//
// Turns a vrased monitor violation, or power-on, into a sequenced MCU reset:
//   1. latch the violation cause and count the violation,
//   2. zero the secure RAM region one 16-bit word at a time over a
//      ready/valid write port,
//   3. hold the MCU in reset for a fixed number of cycles,
//   4. release only once the monitor has gone quiet.
// The reset value of the sequencer is the ASSERT state, so every power-on
// performs a full wipe before the core is let out of reset.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   viol        violation level from vrased (its `reset` output), active high
//   viol_cause  {atomicity, ac, xstack} cause flags, valid while viol=1
//   wipe_rdy    RAM write port accepts a write this cycle
//   puc_rst     MCU reset (drives the core's PUC input), active high
//   wipe_en     wipe write request (valid)
//   wipe_addr   wipe byte address
//   wipe_data   wipe data, always zero
//   busy        sequence in progress (state != IDLE)
//   cause       latched {por, atomicity, ac, xstack}
//   viol_count  number of accepted violations, saturating
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vrased_reset_seq #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] WIPE_BASE   = 16'h0400,
  parameter int unsigned           WIPE_WORDS  = 256,
  parameter int unsigned           HOLD_CYCLES = 16,
  parameter int unsigned           CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  viol,
  input  logic [2:0]            viol_cause,
  input  logic                  wipe_rdy,
  output logic                  puc_rst,
  output logic                  wipe_en,
  output logic [ADDR_WIDTH-1:0] wipe_addr,
  output logic [15:0]           wipe_data,
  output logic                  busy,
  output logic [3:0]            cause,
  output logic [CNT_WIDTH-1:0]  viol_count
);

  // Counter widths sized so the largest loaded value always fits.
  localparam int unsigned WordW = (WIPE_WORDS  > 1) ? $clog2(WIPE_WORDS)  : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [WordW-1:0] LastWord = WordW'(WIPE_WORDS - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StWipe,
    StHold
  } state_e;

  state_e                state_q,      state_d;
  logic                  puc_rst_q,    puc_rst_d;
  logic                  busy_q,       busy_d;
  logic                  wipe_en_q,    wipe_en_d;
  logic [ADDR_WIDTH-1:0] wipe_addr_q,  wipe_addr_d;
  logic [3:0]            cause_q,      cause_d;
  logic [CNT_WIDTH-1:0]  viol_count_q, viol_count_d;
  logic                  viol_prev_q,  viol_prev_d;
  logic [WordW-1:0]      word_cnt_q,   word_cnt_d;
  logic [HoldW-1:0]      hold_cnt_q,   hold_cnt_d;

  logic                  write_done;
  logic [CNT_WIDTH-1:0]  count_inc;

  // A write completes on every edge where the request is up and accepted.
  assign write_done = wipe_en_q & wipe_rdy;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  assign count_inc = (viol_count_q == {CNT_WIDTH{1'b1}}) ? viol_count_q
                                                         : viol_count_q + CNT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    puc_rst_d    = puc_rst_q;
    busy_d       = busy_q;
    wipe_en_d    = wipe_en_q;
    wipe_addr_d  = wipe_addr_q;
    cause_d      = cause_q;
    viol_count_d = viol_count_q;
    viol_prev_d  = viol;
    word_cnt_d   = word_cnt_q;
    hold_cnt_d   = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (viol) begin
          // New sequence: previous cause (including por) is overwritten here.
          state_d      = StAssert;
          cause_d      = {1'b0, viol_cause};
          viol_count_d = count_inc;
          puc_rst_d    = 1'b1;
          busy_d       = 1'b1;
        end
      end

      StAssert: begin
        state_d     = StWipe;
        wipe_addr_d = WIPE_BASE;
        word_cnt_d  = '0;
        wipe_en_d   = 1'b1;
      end

      StWipe: begin
        // Address and request stay frozen while the port stalls.
        if (write_done) begin
          wipe_addr_d = wipe_addr_q + ADDR_WIDTH'(2);
          word_cnt_d  = word_cnt_q + WordW'(1);
          if (word_cnt_q == LastWord) begin
            wipe_en_d  = 1'b0;
            hold_cnt_d = HoldLoad;
            state_d    = StHold;
          end
        end
      end

      StHold: begin
        if (hold_cnt_q == '0) begin
          if (viol) begin
            // Monitor still complaining: restart the hold window.
            hold_cnt_d = HoldLoad;
          end else begin
            state_d   = StIdle;
            puc_rst_d = 1'b0;
            busy_d    = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
      end

      default: begin
        state_d = StAssert;
      end
    endcase

    // Violations arriving mid-sequence accumulate into the cause and are
    // counted once per rising edge; the wipe itself is not restarted.
    if (state_q != StIdle && viol) begin
      cause_d = cause_q | {1'b0, viol_cause};
      if (!viol_prev_q) begin
        viol_count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StAssert;
      puc_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
      wipe_en_q    <= 1'b0;
      wipe_addr_q  <= WIPE_BASE;
      cause_q      <= 4'b1000;
      viol_count_q <= '0;
      viol_prev_q  <= 1'b0;
      word_cnt_q   <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      puc_rst_q    <= puc_rst_d;
      busy_q       <= busy_d;
      wipe_en_q    <= wipe_en_d;
      wipe_addr_q  <= wipe_addr_d;
      cause_q      <= cause_d;
      viol_count_q <= viol_count_d;
      viol_prev_q  <= viol_prev_d;
      word_cnt_q   <= word_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign puc_rst    = puc_rst_q;
  assign busy       = busy_q;
  assign wipe_en    = wipe_en_q;
  assign wipe_addr  = wipe_addr_q;
  assign wipe_data  = 16'h0000;
  assign cause      = cause_q;
  assign viol_count = viol_count_q;

endmodule

// File: doc/vrased_reset_seq.md
Name: vrased_reset_seq

Overview:
- Sits directly downstream of the vrased monitor and consumes its violation output (`reset`) plus a per-rule cause vector.
- Turns a violation, or power-on, into a properly sequenced MCU reset:
  - latches the cause,
  - wipes the secure RAM region word by word over a ready/valid write port,
  - holds the MCU in reset for a fixed count,
  - releases only once the monitor is quiet.
- The output `puc_rst` drives the core's PUC input.

Parameters:
- ADDR_WIDTH, 16, width of the wipe address bus.
- WIPE_BASE, 16'h0400, first byte address wiped.
- WIPE_WORDS, 256, number of 16-bit words wiped (must be ≥1).
- HOLD_CYCLES, 16, cycles `puc_rst` is held after the wipe (must be ≥1).
- CNT_WIDTH, 8, width of the violation counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- viol  in  1  violation level from vrased (`reset`), active high.
- viol_cause  in  3  {atomicity, ac, xstack} cause flags, valid while `viol`=1.
- wipe_rdy  in  1  RAM write port accepts a write this cycle.
- puc_rst  out  1  MCU reset, active high.
- wipe_en  out  1  wipe write request (valid).
- wipe_addr  out  ADDR_WIDTH  wipe byte address.
- wipe_data  out  16  wipe data, constant 0.
- busy  out  1  sequence in progress (state ≠ IDLE).
- cause  out  4  latched {por, atomicity, ac, xstack}.
- viol_count  out  CNT_WIDTH  number of violations accepted, saturating.

Behaviour:
- Reset values while `reset_n` is low:
  - state=ASSERT, `puc_rst`=1, `busy`=1, `wipe_en`=0.
  - `wipe_addr`=WIPE_BASE, `cause`=4'b1000 (por), `viol_count`=0.
- Boot behaviour: every power-on therefore performs a full wipe.
- All outputs are registered; `wipe_data` is tied to 0.
- States and transitions:
  - IDLE: `puc_rst`=0, `busy`=0.
    - If `viol`=1 at a clk edge, go to ASSERT.
    - On that edge: `cause` <= {0, viol_cause}, `viol_count` += 1 (saturating at all-ones), `puc_rst` <= 1.
    - Latency: `viol` sampled high at edge k gives `puc_rst` high after edge k.
  - ASSERT: lasts exactly 1 cycle.
    - Load `wipe_addr`=WIPE_BASE and word counter=0.
    - Go to WIPE with `wipe_en`=1.
  - WIPE: `wipe_en`=1.
    - A write completes on each edge where `wipe_en`=1 and `wipe_rdy`=1; then `wipe_addr` += 2 (wraps modulo 2^ADDR_WIDTH) and the counter increments.
    - `wipe_addr` and `wipe_en` are held stable while `wipe_rdy`=0.
    - On the WIPE_WORDS-th completed write: `wipe_en` <= 0, hold counter <= HOLD_CYCLES-1, go to HOLD.
  - HOLD: the counter decrements each cycle.
    - At counter 0 with `viol`=0, go to IDLE (`puc_rst` <= 0, `busy` <= 0).
    - At counter 0 with `viol`=1, reload HOLD_CYCLES-1 and stay.
- `puc_rst`=1 in ASSERT, WIPE and HOLD.
- Violations during ASSERT/WIPE/HOLD:
  - `viol_cause` is OR-ed into `cause` each cycle `viol`=1.
  - `viol_count` increments only on a rising edge of `viol` (registered previous value).
  - The wipe is not restarted; the HOLD exit check covers persistent violations.
- Cause retention: `cause` stays valid after release until the next IDLE→ASSERT transition overwrites it.
- Minimum sequence length with `wipe_rdy` tied high: 1 + WIPE_WORDS + HOLD_CYCLES cycles of `puc_rst`.
- `reset_n` asserted mid-sequence: immediate return to reset values. The wipe restarts from WIPE_BASE after release.

Test Plan (HOLD_CYCLES=4, WIPE_WORDS=4, WIPE_BASE=16'h0400, wipe_rdy=1 unless stated):
- Power-on:
  - Stimulus: `reset_n` low 2 cycles, then high.
  - Response: `puc_rst`=1 for 9 cycles; writes to 0x0400, 0x0402, 0x0404, 0x0406 with data 0.
  - After release: `cause`=4'b1000, `viol_count`=0, `busy`=0.
- X_Stack violation:
  - Stimulus: in IDLE, `viol`=1 for 1 cycle with `viol_cause`=3'b001.
  - Response: `puc_rst` rises the next cycle; `cause`=4'b0001, `viol_count`=1; 4 wipe writes; release after 9 cycles.
- Backpressure:
  - Stimulus: `wipe_rdy` low for 3 cycles while `wipe_addr`=0x0402.
  - Response: `wipe_addr` and `wipe_en` hold; sequence lengthens to exactly 12 cycles.
- Persistent violation:
  - Stimulus: AC `viol` held high (`viol_cause`=3'b010) through HOLD.
  - Response: HOLD reloads; `puc_rst` stays 1 until 4 cycles after `viol` falls; `viol_count` increments once.
- Nested cause:
  - Stimulus: xstack violation, then atomicity `viol` pulse during WIPE.
  - Response: `cause`=4'b0101, `viol_count`=2; no wipe restart.
- Mid-sequence reset:
  - Stimulus: `reset_n` low during WIPE at 0x0404.
  - Response: outputs go to reset values asynchronously; the next wipe starts at 0x0400.
